iwm_write: RTL
==============

IWM_WRITE -- requirements
Module: iwm_write

Interface
REQ-001 SHALL have parameter BIT_CELL_CLKS, default 16, meaning clk8 cycles per bit cell (2 us at 8 MHz).
REQ-002 SHALL have port clk8, input, 1: sole clock.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port wrMode, input, 1: write mode (Q7 high and selected drive enabled); level.
REQ-005 SHALL have port dataLoad, input, 1: one-cycle strobe, CPU wrote the data register.
REQ-006 SHALL have port dataIn, input, 8: byte to write, sampled with dataLoad.
REQ-007 SHALL have port _iwmBusy, output, 1: 1 = write buffer empty, ready for a byte.
REQ-008 SHALL have port _writeUnderrun, output, 1: 0 = underrun occurred.
REQ-009 SHALL have port wrData, output, 1: flux line; each toggle encodes a 1.
REQ-010 SHALL have port wrReq, output, 1: write gate to drive, high while serialising.
REQ-011 SHALL have port bitStrobe, output, 1: one-cycle pulse at every bit-cell boundary.

Function
REQ-012 SHALL implement states IDLE, SHIFT and UNDERRUN, plus a 1-byte buffer (bufFull flag), an 8-bit shift register, a cell counter (log2 BIT_CELL_CLKS bits) and a 3-bit bit counter.
REQ-013 SHALL set bufFull and capture dataIn on any edge where dataLoad=1, wrMode=1 and state is not UNDERRUN.
- A load into an already full buffer overwrites it (last write wins).
REQ-014 SHALL drive _iwmBusy = ~bufFull.
REQ-015 SHALL, in IDLE with wrMode=1 and bufFull=1, on the next edge: load the shift register from the buffer, clear bufFull, set the cell counter to BIT_CELL_CLKS-1 and the bit counter to 0, and enter SHIFT.
REQ-016 SHALL, in SHIFT, decrement the cell counter each cycle; a cell-counter value of 0 is a boundary.
REQ-017 SHALL, at each boundary edge:
- toggle wrData if shiftReg[7]=1;
- shift the register left;
- increment the bit counter;
- reload the cell counter to BIT_CELL_CLKS-1;
- pulse bitStrobe for that cycle.
REQ-018 SHALL, at the 8th boundary with bufFull=1, reload the shift register from the buffer and clear bufFull in the same edge, with no gap cell.
REQ-019 SHALL, at the 8th boundary with bufFull=0, enter UNDERRUN and set _writeUnderrun=0 after that edge.
REQ-020 SHALL, on a dataLoad coinciding with a buffer-to-shift transfer, capture the new byte so that bufFull remains 1.
REQ-021 SHALL drive wrReq=1 exactly while in SHIFT.
REQ-022 SHALL, in UNDERRUN, ignore dataLoad and remain there until wrMode=0.
REQ-023 SHALL, when wrMode=0 in any state, on the next edge:
- enter IDLE;
- clear bufFull;
- set _writeUnderrun=1;
- keep the wrData level (abort mid-byte emits no further toggles).
REQ-024 SHALL keep the wrData level across byte and state transitions; only reset forces it.

Reset
REQ-025 SHALL, on reset=1 at an edge, set:
- state IDLE;
- bufFull 0 (_iwmBusy=1);
- _writeUnderrun 1;
- wrData 0, wrReq 0, bitStrobe 0;
- all counters and the shift register to 0.
REQ-026 SHALL let reset override every other input, including mid-byte.

Structure
REQ-027 SHALL place the state encoding and the BIT_CELL_CLKS default constant in shared package iwm_pkg, which the existing IWM block may also import.
REQ-028 SHALL be a single module with no sub-module; the cell timer is inline.

Verification
Timing below is in edges after the dataLoad edge N.
REQ-029 SHALL cover: wrMode=1, load 0xA5 then a second byte before N+129 -> wrReq=1 from N+1, _iwmBusy=1 at N+1; wrData toggles 0->1 at N+17, 1->0 at N+49, 0->1 at N+97, 1->0 at N+129; bitStrobe pulses at N+1+16k for k=1..8.
REQ-030 SHALL cover: load 0xFF, then 0x00 at N+20 -> 8 toggles at N+17..N+129 with 16-cycle spacing; no toggles from N+145 to N+257; wrReq continuous; _iwmBusy 0 from N+21 to N+129, 1 after.
REQ-031 SHALL cover: load 0x96 only -> at N+129 state UNDERRUN, _writeUnderrun=0, wrReq=0; a later dataLoad is ignored; wrMode=0 restores _writeUnderrun=1.
REQ-032 SHALL cover: load 0xFF, drop wrMode at N+40 -> wrReq=0 from N+41, wrData holds its N+40 level, _iwmBusy=1, no further toggles.
REQ-033 SHALL cover: reset=1 at N+60 mid-byte -> next cycle wrData=0, wrReq=0, _iwmBusy=1, _writeUnderrun=1, state IDLE.
REQ-034 SHALL cover: dataLoad at the exact N+129 reload edge while bufFull=1 -> the old buffer byte shifts next, the new byte is held, and bufFull stays 1.

Source files
------------

// File: rtl/iwm_pkg.sv
// Shared IWM constants: state encoding and bit-cell timing.
// Imported by the write serialiser and the rest of the IWM block.
package iwm_pkg;

  localparam int IWM_BIT_CELL_CLKS = 16;

  localparam logic [1:0] IWM_ST_IDLE     = 2'd0;
  localparam logic [1:0] IWM_ST_SHIFT    = 2'd1;
  localparam logic [1:0] IWM_ST_UNDERRUN = 2'd2;

  function automatic int iwm_cell_w(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/iwm_write.sv
// IWM write serialiser: one-byte buffer feeding an 8-bit shifter.
// Each 1 bit toggles the flux line at the end of its bit cell.
module iwm_write
  import iwm_pkg::*;
#(
  parameter int BIT_CELL_CLKS = IWM_BIT_CELL_CLKS
) (
  input  logic       clk8,
  input  logic       reset,
  input  logic       wrMode,
  input  logic       dataLoad,
  input  logic [7:0] dataIn,
  output logic       _iwmBusy,
  output logic       _writeUnderrun,
  output logic       wrData,
  output logic       wrReq,
  output logic       bitStrobe
);

  localparam int CW = iwm_cell_w(BIT_CELL_CLKS);
  localparam logic [CW-1:0] CELL_MAX = CW'(BIT_CELL_CLKS - 1);

  logic [1:0]    state_q, state_d;
  logic          buf_full_q, buf_full_d;
  logic [7:0]    buf_q, buf_d;
  logic [7:0]    shift_q, shift_d;
  logic [CW-1:0] cell_q, cell_d;
  logic [2:0]    bit_q, bit_d;
  logic          wr_data_q, wr_data_d;
  logic          und_n_q, und_n_d;
  logic          strobe_q, strobe_d;
  logic          boundary;
  logic          load_ok;

  assign boundary = (state_q == IWM_ST_SHIFT) && (cell_q == '0);
  assign load_ok  = dataLoad && wrMode && (state_q != IWM_ST_UNDERRUN);

  always_comb begin
    state_d    = state_q;
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    shift_d    = shift_q;
    cell_d     = cell_q;
    bit_d      = bit_q;
    wr_data_d  = wr_data_q;
    und_n_d    = und_n_q;
    strobe_d   = 1'b0;

    if (!wrMode) begin
      state_d    = IWM_ST_IDLE;
      buf_full_d = 1'b0;
      und_n_d    = 1'b1;
    end else begin
      case (state_q)
        IWM_ST_IDLE: begin
          if (buf_full_q) begin
            shift_d    = buf_q;
            buf_full_d = 1'b0;
            cell_d     = CELL_MAX;
            bit_d      = 3'd0;
            state_d    = IWM_ST_SHIFT;
          end
        end
        IWM_ST_SHIFT: begin
          if (boundary) begin
            if (shift_q[7]) wr_data_d = ~wr_data_q;
            shift_d  = {shift_q[6:0], 1'b0};
            bit_d    = bit_q + 3'd1;
            cell_d   = CELL_MAX;
            strobe_d = 1'b1;
            // last cell of the byte: chain the buffer with no gap
            if (bit_q == 3'd7) begin
              if (buf_full_q) begin
                shift_d    = buf_q;
                buf_full_d = 1'b0;
              end else begin
                state_d = IWM_ST_UNDERRUN;
                und_n_d = 1'b0;
              end
            end
          end else begin
            cell_d = cell_q - CW'(1);
          end
        end
        default: ;
      endcase

      if (load_ok) begin
        buf_d      = dataIn;
        buf_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk8) begin
    if (reset) begin
      state_q    <= IWM_ST_IDLE;
      buf_full_q <= 1'b0;
      buf_q      <= 8'h00;
      shift_q    <= 8'h00;
      cell_q     <= '0;
      bit_q      <= 3'd0;
      wr_data_q  <= 1'b0;
      und_n_q    <= 1'b1;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      shift_q    <= shift_d;
      cell_q     <= cell_d;
      bit_q      <= bit_d;
      wr_data_q  <= wr_data_d;
      und_n_q    <= und_n_d;
      strobe_q   <= strobe_d;
    end
  end

  assign _iwmBusy       = ~buf_full_q;
  assign _writeUnderrun = und_n_q;
  assign wrData         = wr_data_q;
  assign wrReq          = (state_q == IWM_ST_SHIFT);
  assign bitStrobe      = strobe_q;

endmodule
